// File: rtl/serv_bufreg_w_pkg.sv
// Shared constants and helpers for the W-bit SERV buffer register.
// Holds the load/store size encodings and the misalignment rule.
package serv_bufreg_w_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;

    // Any size with bit1 set (10, 11) is a word access.
    function automatic logic misalign_chk(
        input logic [1:0] size,
        input logic [1:0] lsb
    );
        logic m;
        m = 1'b0;
        unique case (size)
            LS_BYTE: m = 1'b0;
            LS_HALF: m = lsb[0];
            default: m = |lsb;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/serv_bufreg_funnel.sv
// W-bit window select over a (3W-2)-bit vector for fine shifts.
// Ports: i_mux window source, i_shift_op/i_right/i_shamt select, o_q window.
module serv_bufreg_funnel #(
    parameter int W = 4,
    parameter int L = $clog2(W)
) (
    input  logic [3*W-3:0] i_mux,
    input  logic           i_shift_op,
    input  logic           i_right,
    input  logic [L-1:0]   i_shamt,
    output logic [W-1:0]   o_q
);

    localparam int SW = L + 1;
    localparam logic [SW-1:0] SA_MID = SW'(W - 1);

    logic [SW-1:0] sa;

    // Offset W-1 skips the tail and lands on data[W-1:0].
    always_comb begin
        sa = SA_MID;
        if (i_shift_op) begin
            if (i_right)
                sa = SA_MID + {1'b0, i_shamt};
            else
                sa = {1'b0, ~i_shamt};
        end
    end

    assign o_q = i_mux[sa +: W];

endmodule

// File: rtl/serv_bufreg_w.sv
// W-bit-per-cycle SERV buffer register: serial rs1+imm adder, shift data,
// address lsbs and registered misalignment flag. Ports: counter strobes
// (i_cnt0/1/done), i_en, i_init, operand chunks i_rs1/i_imm, shift controls;
// outputs o_q stream, o_lsb, o_misalign, o_dbus_adr, o_ext_rs1.
module serv_bufreg_w
    import serv_bufreg_w_pkg::*;
#(
    parameter int W     = 1,
    parameter int MDU   = 0,
    parameter int ALIGN = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cnt0,
    input  logic          i_cnt1,
    input  logic          i_cnt_done,
    input  logic          i_en,
    input  logic          i_init,
    input  logic          i_mdu_op,
    input  logic          i_rs1_en,
    input  logic          i_imm_en,
    input  logic          i_clr_lsb,
    input  logic          i_shift_op,
    input  logic          i_right_shift_op,
    input  logic [4:0]    i_shamt,
    input  logic          i_sh_signed,
    input  logic [1:0]    i_ls_size,
    input  logic [W-1:0]  i_rs1,
    input  logic [W-1:0]  i_imm,
    output logic [W-1:0]  o_q,
    output logic [1:0]    o_lsb,
    output logic          o_misalign,
    output logic [31:0]   o_dbus_adr,
    output logic [31:0]   o_ext_rs1
);

    logic [W-1:0] rs1_g;
    logic [W-1:0] imm_g;
    logic [W-1:0] q;
    logic         c;
    logic         carry_r;
    logic         clr;
    logic [31:0]  data;
    logic [1:0]   lsb;
    logic         mdu_gate;

    assign clr   = i_cnt0 & i_clr_lsb;
    assign rs1_g = i_rs1 & {W{i_rs1_en}};
    assign imm_g = i_imm & {W{i_imm_en}} & ~W'(clr);

    assign {c, q} = {1'b0, rs1_g} + {1'b0, imm_g} + {{W{1'b0}}, carry_r};

    // Dropping i_en clears the carry so each pass starts clean.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            carry_r <= 1'b0;
        else
            carry_r <= c & i_en;
    end

    if (W == 1) begin : g_w1
        logic unused_w1;
        assign unused_w1 = ^{i_shift_op, i_right_shift_op, i_shamt};

        // data[1:0] only moves on the first two init cycles, so it keeps
        // the address lsbs while the upper bits keep filling.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                data <= '0;
            end else begin
                if (i_en)
                    data[31:2] <= {i_init ? q[0] : (i_sh_signed & data[31]),
                                   data[31:3]};
                if (i_en & (!i_init | i_cnt0 | i_cnt1))
                    data[1:0] <= {i_init ? q[0] : data[2], data[1]};
            end
        end

        assign lsb = data[1:0];
        assign o_q = data[0] & i_en;
    end else begin : g_wn
        localparam int L = $clog2(W);

        logic [W-2:0] tail;
        logic [1:0]   lsb_r;
        logic [W-1:0] fq;
        logic         unused_wn;

        assign unused_wn = ^{i_cnt1, i_shamt[4:L]};

        // tail keeps the previous chunk's upper bits for left shifts and
        // is zeroed at pass end so the next pass fills with zeros.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                data  <= '0;
                tail  <= '0;
                lsb_r <= '0;
            end else if (i_en) begin
                data <= {i_init ? q : {W{i_sh_signed & data[31]}},
                         data[31:W]};
                tail <= data[W-1:1] & {(W-1){~i_cnt_done}};
                if (i_cnt0)
                    lsb_r <= q[1:0];
            end
        end

        serv_bufreg_funnel #(
            .W (W),
            .L (L)
        ) u_funnel (
            .i_mux      ({data[2*W-2:0], tail}),
            .i_shift_op (i_shift_op),
            .i_right    (i_right_shift_op),
            .i_shamt    (i_shamt[L-1:0]),
            .o_q        (fq)
        );

        assign lsb = lsb_r;
        assign o_q = fq & {W{i_en}};
    end

    assign mdu_gate = (MDU != 0) & i_mdu_op;

    if (ALIGN != 0) begin : g_align
        logic misalign_r;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                misalign_r <= 1'b0;
            else if (i_en & i_init & i_cnt_done)
                misalign_r <= misalign_chk(i_ls_size, lsb) & ~mdu_gate;
        end

        assign o_misalign = misalign_r & ~mdu_gate;
    end else begin : g_noalign
        logic unused_al;
        assign unused_al  = ^{i_ls_size};
        assign o_misalign = 1'b0;
    end

    assign o_lsb      = lsb & {2{~mdu_gate}};
    assign o_dbus_adr = {data[31:2], 2'b00};
    assign o_ext_rs1  = data;

endmodule

// File: tb/tb_serv_bufreg_w.sv
// Self-checking bench for serv_bufreg_w: directed table on a W=4 core,
// shift sequences, reset abort, and random sum sweeps at W=1,2,8.
module tb_serv_bufreg_w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic go = 1'b0;
    logic rst_n = 1'b0;

    logic       cnt0 = 0, cnt1 = 0, cnt_done = 0, en = 0, init = 0;
    logic       mdu_op = 0, rs1_en = 0, imm_en = 0, clr_lsb = 0;
    logic       shift_op = 0, right = 0, sh_signed = 0;
    logic [4:0] shamt = 0;
    logic [1:0] ls_size = 0;
    logic [3:0] rs1c = 0, immc = 0;
    logic [3:0] q;
    logic [1:0] lsb;
    logic       mis;
    logic [31:0] adr, ext;

    serv_bufreg_w #(.W(4), .MDU(1), .ALIGN(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cnt0(cnt0), .i_cnt1(cnt1),
        .i_cnt_done(cnt_done), .i_en(en), .i_init(init),
        .i_mdu_op(mdu_op), .i_rs1_en(rs1_en), .i_imm_en(imm_en),
        .i_clr_lsb(clr_lsb), .i_shift_op(shift_op),
        .i_right_shift_op(right), .i_shamt(shamt),
        .i_sh_signed(sh_signed), .i_ls_size(ls_size),
        .i_rs1(rs1c), .i_imm(immc), .o_q(q), .o_lsb(lsb),
        .o_misalign(mis), .o_dbus_adr(adr), .o_ext_rs1(ext)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One 8-cycle pass on the W=4 core; also releases reset on cycle 0.
    task automatic pass4(input logic [31:0] r, input logic [31:0] im,
                         input logic ini, input logic clr,
                         output logic [31:0] qs);
        qs = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            en = 1; init = ini; clr_lsb = clr;
            cnt0 = (k == 0); cnt1 = (k == 1); cnt_done = (k == 7);
            rs1c = r[4*k +: 4]; immc = im[4*k +: 4];
            if (k == 0) rst_n = 1;
            #1 qs[4*k +: 4] = q;
        end
        @(negedge clk);
        en = 0; init = 0; clr_lsb = 0;
        cnt0 = 0; cnt1 = 0; cnt_done = 0; rs1c = 0; immc = 0;
    endtask

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] imm;
        logic        clr;
        logic [1:0]  size;
        logic        mdu;
        logic [31:0] ext;
        logic [31:0] adr;
        logic [1:0]  lsb;
        logic        mis;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] qs, v, e;
        int s, md, sg;

        tbl[0] = '{32'h0000_0fff, 32'h1, 1'b0, 2'b10, 1'b0,
                   32'h0000_1000, 32'h0000_1000, 2'b00, 1'b0};
        tbl[1] = '{32'h0000_0100, 32'h7, 1'b1, 2'b00, 1'b0,
                   32'h0000_0106, 32'h0000_0104, 2'b10, 1'b0};
        tbl[2] = '{32'h0000_1000, 32'h2, 1'b0, 2'b10, 1'b0,
                   32'h0000_1002, 32'h0000_1000, 2'b10, 1'b1};
        tbl[3] = '{32'h0000_1000, 32'h2, 1'b0, 2'b01, 1'b0,
                   32'h0000_1002, 32'h0000_1000, 2'b10, 1'b0};
        tbl[4] = '{32'h0000_1000, 32'h1, 1'b0, 2'b01, 1'b0,
                   32'h0000_1001, 32'h0000_1000, 2'b01, 1'b1};
        tbl[5] = '{32'h0000_1000, 32'h2, 1'b0, 2'b10, 1'b1,
                   32'h0000_1002, 32'h0000_1000, 2'b00, 1'b0};
        tbl[6] = '{32'hffff_ffff, 32'h3, 1'b0, 2'b11, 1'b0,
                   32'h0000_0002, 32'h0000_0000, 2'b10, 1'b1};
        tbl[7] = '{32'h0000_0010, 32'h20, 1'b0, 2'b00, 1'b0,
                   32'h0000_0030, 32'h0000_0030, 2'b00, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_q", q, 0);
        chk("rst_lsb", lsb, 0);
        chk("rst_mis", mis, 0);
        chk("rst_adr", adr, 0);
        chk("rst_ext", ext, 0);

        rs1_en = 1; imm_en = 1;
        for (int i = 0; i < 8; i++) begin
            ls_size = tbl[i].size;
            mdu_op = tbl[i].mdu;
            pass4(tbl[i].rs1, tbl[i].imm, 1'b1, tbl[i].clr, qs);
            #1;
            chk($sformatf("vec%0d_ext", i), ext, tbl[i].ext);
            chk($sformatf("vec%0d_adr", i), adr, tbl[i].adr);
            chk($sformatf("vec%0d_lsb", i), lsb, tbl[i].lsb);
            chk($sformatf("vec%0d_mis", i), mis, tbl[i].mis);
            mdu_op = 0;
        end

        // Reset in the middle of a pass with a carry in flight.
        ls_size = 2'b10;
        pass4(32'h1000, 32'h3, 1'b1, 1'b0, qs);
        #1 chk("pre_rst_mis", mis, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            en = 1; init = 1; cnt0 = (k == 0); cnt1 = (k == 1);
            cnt_done = 0; rs1c = 4'hf; immc = (k == 0) ? 4'h1 : 4'h0;
        end
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("midrst_q", q, 0);
        chk("midrst_ext", ext, 0);
        chk("midrst_adr", adr, 0);
        chk("midrst_lsb", lsb, 0);
        chk("midrst_mis", mis, 0);
        en = 0; cnt0 = 0; cnt1 = 0; rs1c = 0; immc = 0;
        pass4(32'h5, 32'h0, 1'b1, 1'b0, qs);
        #1 chk("post_rst_carry", ext, 32'h5);

        // Directed shifts.
        imm_en = 0; rs1_en = 1; shift_op = 0;
        pass4(32'h8000_0000, 0, 1'b1, 1'b0, qs);
        rs1_en = 0; shift_op = 1; right = 1; sh_signed = 1; shamt = 5'd3;
        pass4(0, 0, 1'b0, 1'b0, qs);
        chk("sra3", qs, 32'hf000_0000);
        shift_op = 0; right = 0; sh_signed = 0; shamt = 0; rs1_en = 1;
        pass4(32'h1, 0, 1'b1, 1'b0, qs);
        rs1_en = 0; shift_op = 1; shamt = 5'd1;
        pass4(0, 0, 1'b0, 1'b0, qs);
        chk("sll1", qs, 32'h2);

        // Random fine shifts against arithmetic model.
        for (int n = 0; n < 24; n++) begin
            v = $urandom;
            s = $urandom_range(0, 3);
            md = $urandom_range(0, 2);
            sg = $urandom_range(0, 1);
            shift_op = 0; right = 0; sh_signed = 0; rs1_en = 1;
            pass4(v, 0, 1'b1, 1'b0, qs);
            #1 chk("q_idle", q, 0);
            rs1_en = 0;
            shift_op = (md != 0);
            right = (md == 2);
            sh_signed = 1'(sg);
            shamt = {3'($urandom), 2'(s)};
            pass4(0, 0, 1'b0, 1'b0, qs);
            if (md == 0)
                e = v;
            else if (md == 1)
                e = v << s;
            else if (sg != 0)
                e = 32'($signed(v) >>> s);
            else
                e = v >> s;
            chk($sformatf("shift_md%0d_s%0d", md, s), qs, e);
        end
        shift_op = 0;

        go = 1;
        for (int t = 0; t < 60000 && done_cnt < 3; t++)
            @(posedge clk);
        if (done_cnt < 3) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout actual=%0d required=3", done_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int WW = (g == 0) ? 1 : (g == 1) ? 2 : 8;
        localparam int NC = 32 / WW;

        logic          s_c0 = 0, s_c1 = 0, s_cd = 0, s_en = 0;
        logic          s_clr = 0, s_ie = 0;
        logic [1:0]    s_sz = 0;
        logic [WW-1:0] s_r = 0, s_i = 0;
        logic [WW-1:0] s_q;
        logic [1:0]    s_lsb;
        logic          s_mis;
        logic [31:0]   s_adr, s_ext;

        serv_bufreg_w #(.W(WW), .MDU(0), .ALIGN(1)) u_sw (
            .i_clk(clk), .i_rst_n(rst_n), .i_cnt0(s_c0), .i_cnt1(s_c1),
            .i_cnt_done(s_cd), .i_en(s_en), .i_init(1'b1),
            .i_mdu_op(1'b0), .i_rs1_en(1'b1), .i_imm_en(s_ie),
            .i_clr_lsb(s_clr), .i_shift_op(1'b0),
            .i_right_shift_op(1'b0), .i_shamt(5'd0),
            .i_sh_signed(1'b0), .i_ls_size(s_sz),
            .i_rs1(s_r), .i_imm(s_i), .o_q(s_q), .o_lsb(s_lsb),
            .o_misalign(s_mis), .o_dbus_adr(s_adr), .o_ext_rs1(s_ext)
        );

        initial begin
            logic [31:0] r, im, e;
            logic        cl, ie, em;
            logic [1:0]  sz;
            wait (go);
            for (int n = 0; n < 1000; n++) begin
                r = $urandom;
                im = $urandom;
                cl = 1'($urandom_range(0, 1));
                ie = ($urandom_range(0, 3) != 0);
                sz = 2'($urandom_range(0, 3));
                for (int k = 0; k < NC; k++) begin
                    @(negedge clk);
                    s_en = 1; s_c0 = (k == 0); s_c1 = (k == 1);
                    s_cd = (k == NC - 1); s_clr = cl; s_ie = ie; s_sz = sz;
                    s_r = r[WW*k +: WW]; s_i = im[WW*k +: WW];
                end
                @(negedge clk);
                s_en = 0; s_c0 = 0; s_c1 = 0; s_cd = 0;
                e = r + (ie ? (im & ~{31'b0, cl}) : 32'd0);
                em = (sz == 2'b01) ? e[0] : (sz[1] ? |e[1:0] : 1'b0);
                #1;
                chk($sformatf("w%0d_sum", WW), s_ext, e);
                chk($sformatf("w%0d_adr", WW), s_adr, e & 32'hffff_fffc);
                chk($sformatf("w%0d_lsb", WW), s_lsb, e[1:0]);
                chk($sformatf("w%0d_mis", WW), s_mis, em);
            end
            done_cnt++;
        end
    end

endmodule
